// File: rtl/ddc_accumulator.sv
// Frame accumulator for DDC I/Q samples: sums acc_len+1 valid samples per frame
// and presents each frame sum on a single-register AXI-Stream style output.
module ddc_accumulator #(
    parameter int SAMPLE_WIDTH = 32,
    parameter int LEN_WIDTH    = 16,
    parameter int SUM_WIDTH    = 48
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic [2*SAMPLE_WIDTH-1:0] data_in,
    input  logic                      en,
    input  logic [LEN_WIDTH-1:0]      acc_len,
    input  logic                      ovf_clr,
    output logic [2*SUM_WIDTH-1:0]    m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      overflow,
    output logic [31:0]               frame_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic signed [SUM_WIDTH-1:0]    sum_i_q, sum_q_q;
    logic signed [SUM_WIDTH-1:0]    sum_i_next, sum_q_next;
    logic signed [SAMPLE_WIDTH-1:0] sample_i, sample_q;
    logic [LEN_WIDTH-1:0]           count_q, len_q;

    logic start, accept, last, load, drop, handshake;

    function automatic logic signed [SUM_WIDTH-1:0] sign_extend(
        input logic signed [SAMPLE_WIDTH-1:0] s
    );
        return {{(SUM_WIDTH-SAMPLE_WIDTH){s[SAMPLE_WIDTH-1]}}, s};
    endfunction

    assign sample_i = data_in[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
    assign sample_q = data_in[SAMPLE_WIDTH-1:0];

    assign sum_i_next = sum_i_q + sign_extend(sample_i);
    assign sum_q_next = sum_q_q + sign_extend(sample_q);

    // en=0 has priority over a coincident sample: the partial frame is abandoned.
    assign start     = (state_q == IDLE) && en;
    assign accept    = (state_q == ACCUM) && en && valid_in;
    assign last      = accept && (count_q == len_q);
    assign handshake = m_axis_tvalid && m_axis_tready;
    assign load      = last && (!m_axis_tvalid || m_axis_tready);
    assign drop      = last && m_axis_tvalid && !m_axis_tready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en)  state_d = ACCUM;
            ACCUM:   if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_i_q <= '0;
            sum_q_q <= '0;
            count_q <= '0;
            len_q   <= '0;
        end else if (start || last) begin
            sum_i_q <= '0;
            sum_q_q <= '0;
            count_q <= '0;
            len_q   <= acc_len;
        end else if (accept) begin
            sum_i_q <= sum_i_next;
            sum_q_q <= sum_q_next;
            count_q <= count_q + LEN_WIDTH'(1);
        end
    end

    // Single output register; a completing frame may replace a beat that is
    // leaving on the same edge, otherwise it is dropped while the beat waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            frame_count   <= '0;
        end else if (load) begin
            m_axis_tdata  <= {sum_i_next, sum_q_next};
            m_axis_tvalid <= 1'b1;
            frame_count   <= frame_count + 32'd1;
        end else if (handshake) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ddc_accumulator.sv
// Directed bench for ddc_accumulator: scoreboard of expected frame sums,
// output beats checked at the falling edge as they are handshaken.
module tb_ddc_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [63:0] data_in;
    logic        en;
    logic [15:0] acc_len;
    logic        ovf_clr;
    logic [95:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        overflow;
    logic [31:0] frame_count;

    int checks = 0;
    int errors = 0;

    logic [95:0] exp_q[$];

    logic        held = 1'b0;
    logic [95:0] held_data = '0;

    ddc_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .en           (en),
        .acc_len      (acc_len),
        .ovf_clr      (ovf_clr),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .overflow     (overflow),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [47:0] sx(input logic signed [31:0] v);
        return {{16{v[31]}}, v};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [31:0] i, input logic signed [31:0] q);
        valid_in = 1'b1;
        data_in  = {i, q};
        cyc();
        valid_in = 1'b0;
    endtask

    always @(negedge clk) begin
        if (held && m_axis_tvalid) chk("hold", m_axis_tdata, held_data);
        held      = m_axis_tvalid && !m_axis_tready;
        held_data = m_axis_tdata;
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) chk("beat_unexpected", 96'(exp_q.size()), 96'd1);
            else chk("beat", m_axis_tdata, exp_q.pop_front());
        end
    end

    logic signed [47:0] ei, eq;

    initial begin
        rst = 1'b1; valid_in = 1'b0; data_in = '0; en = 1'b0;
        acc_len = '0; ovf_clr = 1'b0; m_axis_tready = 1'b1;
        cyc(); cyc();
        chk("rst_tvalid", 96'(m_axis_tvalid), 96'd0);
        chk("rst_tdata", m_axis_tdata, 96'd0);
        chk("rst_ovf", 96'(overflow), 96'd0);
        chk("rst_fc", 96'(frame_count), 96'd0);
        rst = 1'b0;

        // four-sample frame
        acc_len = 16'd3; en = 1'b1;
        cyc();
        for (int k = 1; k <= 3; k++) send(k, -k);
        chk("len3_early_tvalid", 96'(m_axis_tvalid), 96'd0);
        exp_q.push_back({sx(10), sx(-10)});
        send(4, -4);
        chk("len3_tvalid", 96'(m_axis_tvalid), 96'd1);
        chk("len3_tdata", m_axis_tdata, {sx(10), sx(-10)});
        cyc();
        chk("len3_tvalid_clr", 96'(m_axis_tvalid), 96'd0);
        chk("len3_fc", 96'(frame_count), 96'd1);

        // single-sample frames back to back
        en = 1'b0; cyc();
        acc_len = 16'd0; en = 1'b1; cyc();
        for (int k = 0; k < 8; k++) begin
            logic signed [31:0] si, sq;
            si = $urandom; sq = $urandom;
            exp_q.push_back({sx(si), sx(sq)});
            send(si, sq);
            chk("len0_tvalid", 96'(m_axis_tvalid), 96'd1);
        end
        cyc();
        chk("len0_ovf", 96'(overflow), 96'd0);
        chk("len0_fc", 96'(frame_count), 96'd9);

        // backpressure: frame 1 held, frames 2 and 3 dropped
        en = 1'b0; cyc();
        acc_len = 16'd1; m_axis_tready = 1'b0; en = 1'b1; cyc();
        exp_q.push_back({sx(3), sx(-3)});
        for (int k = 1; k <= 6; k++) send(k, -k);
        cyc();
        chk("bp_ovf", 96'(overflow), 96'd1);
        chk("bp_fc", 96'(frame_count), 96'd10);
        chk("bp_tdata", m_axis_tdata, {sx(3), sx(-3)});
        ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
        chk("bp_ovf_clr", 96'(overflow), 96'd0);
        m_axis_tready = 1'b1; cyc(); cyc();
        chk("bp_drain", 96'(exp_q.size()), 96'd0);

        // en dropped mid-frame, then a full frame
        en = 1'b0; cyc();
        acc_len = 16'd7; en = 1'b1; cyc();
        for (int k = 0; k < 5; k++) send(100, 100);
        en = 1'b0; cyc(); cyc(); cyc();
        chk("abort_tvalid", 96'(m_axis_tvalid), 96'd0);
        chk("abort_fc", 96'(frame_count), 96'd10);
        en = 1'b1; cyc();
        ei = 0; eq = 0;
        for (int k = 1; k <= 8; k++) begin
            ei += sx(k * 7); eq += sx(-k * 3);
        end
        exp_q.push_back({ei, eq});
        for (int k = 1; k <= 8; k++) send(k * 7, -k * 3);
        cyc(); cyc();
        chk("abort_fc2", 96'(frame_count), 96'd11);

        // full-length worst case
        en = 1'b0; cyc();
        acc_len = 16'hFFFF; en = 1'b1; cyc();
        ei = -48'sh8000_0000_0000;
        eq = 48'sh7FFF_FFFF_0000;
        exp_q.push_back({ei, eq});
        for (int k = 0; k < 65536; k++) send(32'sh8000_0000, 32'sh7FFF_FFFF);
        cyc(); cyc();
        chk("big_drain", 96'(exp_q.size()), 96'd0);
        chk("big_fc", 96'(frame_count), 96'd12);

        // reset coinciding with a completing frame while output is occupied
        en = 1'b0; cyc();
        acc_len = 16'd0; m_axis_tready = 1'b0; en = 1'b1; cyc();
        send(5, 6);
        send(7, 8);
        chk("rst_pre_ovf", 96'(overflow), 96'd1);
        chk("rst_pre_tvalid", 96'(m_axis_tvalid), 96'd1);
        rst = 1'b1; ovf_clr = 1'b0;
        send(9, 10);
        chk("rst_mid_tvalid", 96'(m_axis_tvalid), 96'd0);
        chk("rst_mid_fc", 96'(frame_count), 96'd0);
        chk("rst_mid_ovf", 96'(overflow), 96'd0);
        exp_q.delete();

        // reset mid-frame, then a fresh frame with no carry-over
        rst = 1'b0; m_axis_tready = 1'b1; acc_len = 16'd3; cyc();
        send(1000, 1000); send(1000, 1000);
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
        exp_q.push_back({sx(-2), sx(14)});
        send(1, 2); send(-2, 3); send(3, 4); send(-4, 5);
        cyc(); cyc();
        chk("fresh_fc", 96'(frame_count), 96'd1);
        chk("fresh_drain", 96'(exp_q.size()), 96'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
